// File: rtl/fp_arb_pkg.sv
// Shared types and sizing helpers for the FP unit arbiter.
// Imported by the picker and the arbiter top.
package fp_arb_pkg;

    localparam int STATS_CNT_WIDTH = 32;
    localparam int ID_MAX_WIDTH    = 4;

    function automatic int fp_width(input int exp_w, input int frac_w);
        return 1 + exp_w + frac_w;
    endfunction

    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // ID sized for the largest supported requester count (16)
    typedef struct packed {
        logic                    valid;
        logic [ID_MAX_WIDTH-1:0] id;
    } id_stage_t;

endpackage

// File: rtl/fp_arb_rr_picker.sv
// Combinational round-robin picker: first request at or above ptr,
// wrapping from NUM_REQ-1 back to 0.
module fp_arb_rr_picker
    import fp_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int ID_WIDTH = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic [NUM_REQ-1:0]  grant,
    output logic [ID_WIDTH-1:0] idx,
    output logic                any
);

    always_comb begin
        logic found;
        int   cand;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(ptr) + i) % NUM_REQ;
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = ID_WIDTH'(cand);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/fp_unit_arbiter.sv
// Round-robin sharing of one pipelined FP unit with result steering.
// Define FP_UNIT_ARBITER_STATS_EN to add grant counters and inflight count.
module fp_unit_arbiter
    import fp_arb_pkg::*;
#(
    parameter int EXP_WIDTH    = 8,
    parameter int FRAC_WIDTH   = 23,
    parameter int NUM_REQ      = 4,
    parameter int UNIT_LATENCY = 3,
    localparam int FP_WIDTH  = fp_width(EXP_WIDTH, FRAC_WIDTH),
    localparam int ID_WIDTH  = id_width(NUM_REQ),
    localparam int INF_WIDTH = $clog2(UNIT_LATENCY + 1)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NUM_REQ-1:0]          req_valid_i,
    output logic [NUM_REQ-1:0]          req_ready_o,
    input  logic [NUM_REQ*FP_WIDTH-1:0] req_a_i,
    input  logic [NUM_REQ*FP_WIDTH-1:0] req_b_i,
    output logic [NUM_REQ-1:0]          rsp_valid_o,
    output logic [FP_WIDTH-1:0]         rsp_fp_o,
    output logic                        unit_valid_o,
    output logic [FP_WIDTH-1:0]         unit_fp_a_o,
    output logic [FP_WIDTH-1:0]         unit_fp_b_o,
    input  logic                        unit_valid_i,
    input  logic [FP_WIDTH-1:0]         unit_fp_i,
    output logic                        error_o
`ifdef FP_UNIT_ARBITER_STATS_EN
    ,
    output logic [NUM_REQ*STATS_CNT_WIDTH-1:0] grant_cnt_o,
    output logic [INF_WIDTH-1:0]               inflight_o
`endif
);

    logic [NUM_REQ-1:0]  grant;
    logic [ID_WIDTH-1:0] gnt_idx;
    logic                gnt_any;
    logic [ID_WIDTH-1:0] ptr;
    logic [ID_WIDTH-1:0] issue_id;
    id_stage_t           pipe [UNIT_LATENCY];
    id_stage_t           tail;
    logic                hit;

    fp_arb_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req   (req_valid_i),
        .ptr   (ptr),
        .grant (grant),
        .idx   (gnt_idx),
        .any   (gnt_any)
    );

    assign req_ready_o = grant;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr          <= '0;
            issue_id     <= '0;
            unit_valid_o <= 1'b0;
            unit_fp_a_o  <= '0;
            unit_fp_b_o  <= '0;
        end else begin
            unit_valid_o <= gnt_any;
            if (gnt_any) begin
                ptr <= (gnt_idx == ID_WIDTH'(NUM_REQ - 1))
                     ? '0 : gnt_idx + 1'b1;
                issue_id    <= gnt_idx;
                unit_fp_a_o <= req_a_i[gnt_idx*FP_WIDTH +: FP_WIDTH];
                unit_fp_b_o <= req_b_i[gnt_idx*FP_WIDTH +: FP_WIDTH];
            end
        end
    end

    // Stage 0 follows the issue register, so the tail lines up with unit output
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < UNIT_LATENCY; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0].valid <= unit_valid_o;
            pipe[0].id    <= ID_MAX_WIDTH'(issue_id);
            for (int i = 1; i < UNIT_LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign tail     = pipe[UNIT_LATENCY-1];
    assign hit      = unit_valid_i & tail.valid;
    assign rsp_fp_o = unit_fp_i;

    always_comb begin
        rsp_valid_o = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rsp_valid_o[k] = hit && (tail.id == ID_MAX_WIDTH'(k));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            error_o <= 1'b0;
        end else if (unit_valid_i != tail.valid) begin
            error_o <= 1'b1;
        end
    end

`ifdef FP_UNIT_ARBITER_STATS_EN
    logic [STATS_CNT_WIDTH-1:0] cnt [NUM_REQ];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (gnt_any && gnt_idx == ID_WIDTH'(k) && cnt[k] != '1) begin
                    cnt[k] <= cnt[k] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        grant_cnt_o = '0;
        inflight_o  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            grant_cnt_o[k*STATS_CNT_WIDTH +: STATS_CNT_WIDTH] = cnt[k];
        end
        for (int i = 0; i < UNIT_LATENCY; i++) begin
            inflight_o = inflight_o + INF_WIDTH'(pipe[i].valid);
        end
    end
`endif

endmodule

// File: doc/fp_unit_arbiter.md
Name: fp_unit_arbiter

Overview:
- Shares one fixed-latency, fully pipelined two-operand floating-point unit (fp_a/fp_b/valid in, fp/valid out) between NUM_REQ requesters.
- Round-robin arbitration with valid/ready handshake per requester.
- Tracks the requester ID of every in-flight operation in a shift pipeline and steers each result back to its owner.
- Sits between requester blocks and the FP unit wrapper in the datapath.

Parameters:
- EXP_WIDTH, 8, exponent field width.
- FRAC_WIDTH, 23, fraction field width.
- NUM_REQ, 4, number of requesters, 2..16.
- UNIT_LATENCY, 3, FP unit cycles from valid in to valid out, at least 1.
- FP_WIDTH (local), 1+EXP_WIDTH+FRAC_WIDTH.
- ID_WIDTH (local), max(1, clog2(NUM_REQ)).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_valid_i  in  NUM_REQ  per-requester operation valid.
- req_ready_o  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a_i  in  NUM_REQ*FP_WIDTH  operand A, requester k in slice k.
- req_b_i  in  NUM_REQ*FP_WIDTH  operand B, requester k in slice k.
- rsp_valid_o  out  NUM_REQ  one-cycle result pulse to owning requester.
- rsp_fp_o  out  FP_WIDTH  result, broadcast to all requesters.
- unit_valid_o  out  1  to FP unit valid_i.
- unit_fp_a_o  out  FP_WIDTH  to FP unit fp_a_i.
- unit_fp_b_o  out  FP_WIDTH  to FP unit fp_b_i.
- unit_valid_i  in  1  from FP unit valid_o.
- unit_fp_i  in  FP_WIDTH  from FP unit fp_o.
- error_o  out  1  sticky protocol error.

Behaviour:
- Reset (rst_ni=0, async):
  - unit_valid_o, unit_fp_a_o, unit_fp_b_o = 0.
  - All ID-pipe valids = 0; rsp_valid_o = 0; error_o = 0.
  - RR pointer = 0, so requester 0 has highest priority on the first grant.
- Arbitration (combinational from req_valid_i and pointer):
  - Grant = first asserted req_valid_i searching from pointer upward, wrapping NUM_REQ-1 -> 0.
  - req_ready_o = one-hot grant, or all-zero if no request.
  - Transfer occurs when req_valid_i[k] & req_ready_o[k].
  - The unit never back-pressures, so at most one transfer per cycle and the arbiter accepts every cycle a request exists.
  - On transfer, pointer <= granted index + 1, wrapping to 0 after NUM_REQ-1.
  - With no transfer, the pointer holds.
- Issue:
  - Transfer at cycle t: unit_valid_o=1, unit_fp_a_o/unit_fp_b_o = granted operands at t+1 (registered).
  - With no transfer, unit_valid_o=0 and operand registers hold.
- ID pipeline:
  - UNIT_LATENCY stages of {valid, ID_WIDTH id}.
  - Stage 0 loads {unit_valid_o, issued id} in step with the issue register; shifts every cycle.
- Response (combinational):
  - rsp_fp_o = unit_fp_i.
  - rsp_valid_o = onehot(tail id) when unit_valid_i & tail valid, else 0.
  - Accept at t gives rsp_valid_o at t+1+UNIT_LATENCY.
- Error:
  - error_o sets when unit_valid_i differs from tail valid in any cycle.
  - Clears only on reset.
  - On mismatch, rsp_valid_o is forced to 0 that cycle.
- Boundary conditions:
  - Requester deasserting valid without ready is allowed; it simply is not granted.
  - All requesters valid every cycle: strict rotation 0,1,2,...,N-1,0 at one op per cycle.
  - Single requester valid: granted every cycle regardless of pointer.
  - Reset mid-operation: in-flight operations are discarded and no response is issued. The FP unit shares rst_ni, so no spurious unit_valid_i occurs afterwards.

Optional Feature:
- Macro: FP_UNIT_ARBITER_STATS_EN.
- Defined:
  - Adds output grant_cnt_o, NUM_REQ*32 bits: per-requester saturating transfer counters.
  - Counters reset to 0 and stick at 32'hFFFF_FFFF.
  - Adds output inflight_o, clog2(UNIT_LATENCY+1) bits: popcount of ID-pipe valids.
- Undefined:
  - Ports and logic absent; all other behaviour identical.

Decomposition:
- Package fp_arb_pkg:
  - fp_width(exp, frac) and id_width(n) functions.
  - Typedef for the ID-pipe stage struct {valid, id}.
  - Counter width constant STATS_CNT_WIDTH=32.
- Sub-module fp_arb_rr_picker: parameter NUM_REQ.
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, encoded index, any-grant.
  - Purely combinational.
  - Instantiated once; pointer register stays in the top.

Test Plan:
- Reset then req0 only, A=32'h3F800000, B=32'h40000000, with a behavioural 3-cycle adder model -> ready0 same cycle; unit_valid_o at t+1; rsp_valid_o=4'b0001 with rsp_fp_o=32'h40400000 at t+4.
- All four valid continuously for 8 cycles -> grants 0,1,2,3,0,1,2,3; rsp_valid_o follows the same sequence 4 cycles later, back-to-back.
- req1 and req3 valid, pointer=2 -> grant 3 first, then 1, then 3; req0/req2 ready never asserted.
- Assert rst_ni low with 3 operations in flight -> no rsp_valid_o after release; pointer=0; error_o=0.
- Unit model injects unit_valid_i with an empty ID pipe -> error_o=1 next cycle and stays 1; rsp_valid_o=0 that cycle.
- With FP_UNIT_ARBITER_STATS_EN, 5 grants to req2 -> grant_cnt_o slice 2 = 5; inflight_o peaks at 3 under full load.
